fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 102 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
package fifo_arb_pkg;

    localparam int unsigned DefNReq     = 4;
    localparam int unsigned DefWidth    = 8;
    localparam int unsigned DefBurstMax = 4;

    // Arbiter FSM: IDLE arbitrates, GRANT streams beats from the owner.
    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or after rr_ptr, wrapping N_REQ-1 -> 0.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DefNReq
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic                     found,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int unsigned IdxW = $clog2(N_REQ);
    localparam int unsigned CandW = IdxW + 1;

    // One spare bit so rr_ptr + offset never overflows before the wrap correction.
    logic [CandW-1:0] cand;

    // Scan offsets from rr_ptr upward and keep the first hit.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            cand = {1'b0, rr_ptr} + CandW'(off);
            if (cand >= CandW'(N_REQ)) begin
                cand = cand - CandW'(N_REQ);
            end
            if (!found && req[cand[IdxW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter merging N_REQ write requesters into one FIFO write port,
// with bursts of up to BURST_MAX beats per grant and stalls on FIFO full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = DefNReq,
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned BURST_MAX = DefBurstMax
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]         gnt,
    input  logic                     full,
    output logic                     w_en,
    output logic [WIDTH-1:0]         din,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy
);

    localparam int unsigned IdxW = $clog2(N_REQ);
    localparam int unsigned CntW = $clog2(BURST_MAX + 1);

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [CntW-1:0] beat_q, beat_d;
    logic [IdxW-1:0] rr_q, rr_d;

    logic            pick_found;
    logic [IdxW-1:0] pick_idx;
    logic [IdxW-1:0] next_ptr;

    rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .req   (req),
        .rr_ptr(rr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign next_ptr = (owner_q == IdxW'(N_REQ - 1)) ? '0 : owner_q + IdxW'(1);

    // FIFO-side outputs; the write path is combinational so full blocks the beat in-cycle.
    always_comb begin
        busy  = (state_q == StGrant);
        w_en  = busy && req[owner_q] && !full;
        gnt   = '0;
        if (w_en) begin
            gnt[owner_q] = 1'b1;
        end
        din   = busy ? req_data[owner_q*WIDTH +: WIDTH] : '0;
        owner = busy ? owner_q : '0;
    end

    // Next-state: arbitrate in IDLE, count beats in GRANT, release on drop or burst end.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        beat_d  = beat_q;
        rr_d    = rr_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d = StGrant;
                    owner_d = pick_idx;
                    beat_d  = '0;
                end
            end
            StGrant: begin
                if (w_en) begin
                    beat_d = beat_q + CntW'(1);
                end
                // A drop during a full stall also lands here, so the pointer still advances.
                if (!req[owner_q] || (w_en && (beat_q == CntW'(BURST_MAX - 1)))) begin
                    state_d = StIdle;
                    rr_d    = next_ptr;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            owner_q <= '0;
            beat_q  <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            beat_q  <= beat_d;
            rr_q    <= rr_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a random phase,
// checked every cycle against a behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int BM = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt;
    logic           full;
    logic           w_en;
    logic [W-1:0]   din;
    logic [1:0]     owner;
    logic           busy;

    fifo_wr_arbiter #(
        .N_REQ    (N),
        .WIDTH    (W),
        .BURST_MAX(BM)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_data(req_data),
        .gnt     (gnt),
        .full    (full),
        .w_en    (w_en),
        .din     (din),
        .owner   (owner),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-requester source queues: req is "data pending", req_data is the head word.
    logic [W-1:0] src_mem [N][256];
    int           src_head [N];
    int           src_tail [N];

    // Words the DUT actually wrote into the FIFO.
    logic [W-1:0] log_din [4096];
    logic [1:0]   log_src [4096];
    int           wcnt = 0;

    // Model: is someone granted, who, beats so far in this grant, next priority start.
    logic m_busy;
    int   m_owner;
    int   m_beats;
    int   m_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Requester interfaces derived from their queues.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req[i]           = (src_tail[i] != src_head[i]);
            req_data[i*W +: W] = src_mem[i][src_head[i] & 255];
        end
    end

    // Behavioural model update; a predicted write consumes the head of the owner's queue.
    always @(posedge clk or negedge rst) begin : mdl
        int pick;
        pick = -1;
        if (!rst) begin
            m_busy  <= 1'b0;
            m_owner <= 0;
            m_beats <= 0;
            m_ptr   <= 0;
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                if (pick < 0 && req[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
            end
            if (pick >= 0) begin
                m_busy  <= 1'b1;
                m_owner <= pick;
                m_beats <= 0;
            end
        end else if (!req[m_owner]) begin
            m_busy <= 1'b0;
            m_ptr  <= (m_owner + 1) % N;
        end else if (!full) begin
            src_head[m_owner] <= src_head[m_owner] + 1;
            if (m_beats + 1 == BM) begin
                m_busy <= 1'b0;
                m_ptr  <= (m_owner + 1) % N;
            end else begin
                m_beats <= m_beats + 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model, plus invariants and write log.
    always @(negedge clk) begin : cmp
        logic       ew;
        logic [3:0] eg;
        logic [7:0] ed;
        logic [1:0] eo;
        ew = m_busy && req[m_owner] && !full;
        eg = '0;
        if (ew) eg[m_owner] = 1'b1;
        ed = m_busy ? req_data[m_owner*W +: W] : 8'h00;
        eo = m_busy ? 2'(m_owner) : 2'd0;
        chk("w_en", 32'(w_en), 32'(ew));
        chk("gnt", 32'(gnt), 32'(eg));
        chk("din", 32'(din), 32'(ed));
        chk("owner", 32'(owner), 32'(eo));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("no_write_when_full", 32'(w_en & full), 32'd0);
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        if (w_en) begin
            log_din[wcnt & 4095] = din;
            log_src[wcnt & 4095] = owner;
            wcnt++;
        end
    end

    task automatic push(input int i, input logic [W-1:0] v);
        src_mem[i][src_tail[i] & 255] = v;
        src_tail[i]++;
    endtask

    task automatic drop(input int i);
        src_tail[i] = src_head[i];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        full = 1'b0;
        for (int i = 0; i < N; i++) drop(i);
        @(negedge clk);
        chk("rst_w_en", 32'(w_en), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_din", 32'(din), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        step();
        rst = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] wt;
        logic [31:0] bt;
        int          w0;
        int          g2;
        int          n3;
        rst  = 1'b0;
        full = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < 256; j++) src_mem[i][j] = '0;
        end
        step();
        do_reset();

        // Single requester 2 with six words: burst of 4, re-arbitrate, burst of 2.
        w0 = wcnt;
        g2 = 0;
        wt = '0;
        for (int j = 0; j < 6; j++) push(2, 8'hA0 + 8'(j));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            wt[k] = w_en;
            g2 += int'(gnt[2]);
            if (k == 1) chk("p1_owner", 32'(owner), 32'd2);
            step();
        end
        chk("p1_wen_trace", wt, 32'b0011011110);
        chk("p1_gnt2_pulses", 32'(g2), 32'd6);
        chk("p1_fifo_count", 32'(wcnt - w0), 32'd6);
        for (int j = 0; j < 6; j++) begin
            chk("p1_fifo_word", 32'(log_din[(w0 + j) & 4095]), 32'hA0 + 32'(j));
            chk("p1_fifo_src", 32'(log_src[(w0 + j) & 4095]), 32'd2);
        end

        // All four requesting continuously: bursts of 4 in order 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < 12; j++) push(i, 8'((i << 4) + j));
        end
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            chk("p2_wen", 32'(w_en), (k % 5 != 0) ? 32'd1 : 32'd0);
            if (k % 5 != 0) chk("p2_burst_owner", 32'(owner), 32'((k / 5) % 4));
            step();
        end

        // Owner 1 stalled by full for 3 cycles after 2 beats, then finishes 2 more.
        do_reset();
        wt = '0;
        bt = '0;
        for (int j = 0; j < 4; j++) push(1, 8'hB0 + 8'(j));
        for (int k = 0; k < 10; k++) begin
            full = (k >= 3 && k <= 5);
            @(negedge clk);
            wt[k] = w_en;
            bt[k] = busy;
            if (k == 1) chk("p3_owner", 32'(owner), 32'd1);
            step();
        end
        full = 1'b0;
        chk("p3_wen_trace", wt, 32'b0011000110);
        chk("p3_busy_trace", bt, 32'b0011111110);

        // Owner 3 drops req during a full stall; the pointer must still move to 0.
        w0 = wcnt;
        wt = '0;
        bt = '0;
        full = 1'b1;
        for (int j = 0; j < 4; j++) push(3, 8'hD0 + 8'(j));
        for (int k = 0; k < 4; k++) begin
            if (k == 2) drop(3);
            @(negedge clk);
            wt[k] = w_en;
            bt[k] = busy;
            step();
        end
        chk("p4_wen_trace", wt, 32'd0);
        chk("p4_busy_trace", bt, 32'b0110);
        full = 1'b0;
        push(0, 8'hC0);
        push(2, 8'hC2);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 1) chk("p4_next_owner", 32'(owner), 32'd0);
            if (k == 1) chk("p4_next_wen", 32'(w_en), 32'd1);
            step();
        end
        n3 = 0;
        for (int j = w0; j < wcnt; j++) n3 += (log_src[j & 4095] == 2'd3) ? 1 : 0;
        chk("p4_writes_from_3", 32'(n3), 32'd0);

        // Reset mid-burst: no write in the reset cycle, restart from requester 0.
        do_reset();
        for (int j = 0; j < 8; j++) push(2, 8'h50 + 8'(j));
        for (int k = 0; k < 5; k++) begin
            if (k == 2) rst = 1'b0;
            if (k == 3) begin
                rst = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    push(0, 8'h60 + 8'(j));
                    push(1, 8'h70 + 8'(j));
                    push(3, 8'h80 + 8'(j));
                end
            end
            @(negedge clk);
            if (k == 1) chk("p5_owner_before", 32'(owner), 32'd2);
            if (k == 1) chk("p5_wen_before", 32'(w_en), 32'd1);
            if (k == 2) chk("p5_wen_in_reset", 32'(w_en), 32'd0);
            if (k == 2) chk("p5_busy_in_reset", 32'(busy), 32'd0);
            if (k == 4) chk("p5_first_owner", 32'(owner), 32'd0);
            if (k == 4) chk("p5_busy_after", 32'(busy), 32'd1);
            step();
        end

        // Random traffic: pushes, drops and full toggling, checked by the compare process.
        do_reset();
        for (int c = 0; c < 1000; c++) begin
            full = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0 && (src_tail[i] - src_head[i]) < 16) begin
                    push(i, 8'($urandom_range(0, 255)));
                end
                if ($urandom_range(0, 59) == 0) drop(i);
            end
            step();
        end
        full = 1'b0;
        for (int i = 0; i < N; i++) drop(i);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
